// File: rtl/camera_config_sequencer_if.sv
// SCCB write-request handshake between the configuration sequencer (master)
// and the SCCB controller (slave).
interface camera_config_sequencer_if;
    logic       sccb_start;
    logic [7:0] sccb_address;
    logic [7:0] sccb_command;
    logic [7:0] sccb_data;
    logic       sccb_increment_done;
    logic       sccb_busy;
    logic [3:0] sccb_state;

    modport master (
        output sccb_start,
        output sccb_address,
        output sccb_command,
        output sccb_data,
        output sccb_increment_done,
        input  sccb_busy,
        input  sccb_state
    );

    modport slave (
        input  sccb_start,
        input  sccb_address,
        input  sccb_command,
        input  sccb_data,
        input  sccb_increment_done,
        output sccb_busy,
        output sccb_state
    );
endinterface

// File: rtl/camera_config_sequencer.sv
// Walks a {reg,val} table and issues one SCCB write per entry, with delay
// entries, an end marker, busy/idle timeouts and done/error reporting.
module camera_config_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR    = 8'h42,
    parameter int          ROM_AW        = 8,
    parameter logic [19:0] POWER_UP_WAIT = 20'd1_000_000,
    parameter logic [19:0] DELAY_CYCLES  = 20'd500_000,
    parameter logic [19:0] TIMEOUT       = 20'd200_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              config_start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    camera_config_sequencer_if.master sccb,
    output logic              config_busy,
    output logic              config_done,
    output logic              config_error
);

    typedef enum logic [3:0] {
        S_PWR_WAIT, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_XFER,
        S_ACK, S_DELAY, S_DONE, S_ERROR
    } state_t;

    state_t            r_state, w_state_next;
    logic [19:0]       r_cnt, w_cnt_next;
    logic [ROM_AW-1:0] r_addr, w_addr_next;
    logic [7:0]        r_cmd, w_cmd_next;
    logic [7:0]        r_data, w_data_next;
    logic              r_start, w_start_next;
    logic              r_inc_done, w_inc_done_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_error, w_error_next;
    logic              w_addr_last;

    assign w_addr_last = (r_addr == '1);

    // State register; outputs are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_PWR_WAIT;
            r_cnt      <= POWER_UP_WAIT;
            r_addr     <= '0;
            r_cmd      <= 8'h00;
            r_data     <= 8'h00;
            r_start    <= 1'b0;
            r_inc_done <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_addr     <= w_addr_next;
            r_cmd      <= w_cmd_next;
            r_data     <= w_data_next;
            r_start    <= w_start_next;
            r_inc_done <= w_inc_done_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_error    <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_cmd_next   = r_cmd;
        w_data_next  = r_data;
        case (r_state)
            S_PWR_WAIT: begin
                if (r_cnt == 20'd0) w_state_next = S_FETCH;
                else                w_cnt_next   = r_cnt - 20'd1;
            end
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                if (rom_data == 16'hFFFF) begin
                    w_state_next = S_DONE;
                end else if (rom_data == 16'hFFF0) begin
                    w_cnt_next   = DELAY_CYCLES;
                    w_state_next = S_DELAY;
                end else begin
                    w_cmd_next   = rom_data[15:8];
                    w_data_next  = rom_data[7:0];
                    w_cnt_next   = TIMEOUT;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb.sccb_busy) begin
                    w_cnt_next   = TIMEOUT;
                    w_state_next = S_WAIT_XFER;
                end else if (r_cnt == 20'd0) begin
                    w_state_next = S_ERROR;
                end else begin
                    w_cnt_next   = r_cnt - 20'd1;
                end
            end
            S_WAIT_XFER: begin
                if (!sccb.sccb_busy)      w_state_next = S_ACK;
                else if (r_cnt == 20'd0)  w_state_next = S_ERROR;
                else                      w_cnt_next   = r_cnt - 20'd1;
            end
            S_ACK: begin
                if (sccb.sccb_state == 4'd0) begin
                    if (w_addr_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_addr_next  = r_addr + 1'b1;
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt != 20'd0) begin
                    w_cnt_next = r_cnt - 20'd1;
                end else if (w_addr_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_addr_next  = r_addr + 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_DONE, S_ERROR: w_state_next = r_state;
            default: begin
                w_cnt_next   = POWER_UP_WAIT;
                w_state_next = S_PWR_WAIT;
            end
        endcase

        // A restart request is honoured only while no table walk is active.
        if (config_start &&
            (r_state == S_PWR_WAIT || r_state == S_DONE || r_state == S_ERROR)) begin
            w_addr_next  = '0;
            w_state_next = S_FETCH;
        end
    end

    always_comb begin
        w_start_next    = (w_state_next == S_ISSUE);
        w_inc_done_next = (w_state_next == S_ACK);
        w_busy_next     = !(w_state_next == S_DONE || w_state_next == S_ERROR);
        w_done_next     = (w_state_next == S_DONE);
        w_error_next    = (w_state_next == S_ERROR);
    end

    assign rom_addr                 = r_addr;
    assign sccb.sccb_start          = r_start;
    assign sccb.sccb_address        = SLAVE_ADDR;
    assign sccb.sccb_command        = r_cmd;
    assign sccb.sccb_data           = r_data;
    assign sccb.sccb_increment_done = r_inc_done;
    assign config_busy              = r_busy;
    assign config_done              = r_done;
    assign config_error             = r_error;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Directed bench for camera_config_sequencer with a small SCCB controller
// model and a synchronous table ROM.
module tb_camera_config_sequencer;

    localparam int          ROM_AW = 4;
    localparam logic [19:0] PUW    = 20'd10;
    localparam logic [19:0] DLY    = 20'd50;
    localparam logic [19:0] TMO    = 20'd100;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              config_start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data = 16'hFFFF;
    logic              config_busy, config_done, config_error;

    camera_config_sequencer_if sccb_if ();

    camera_config_sequencer #(
        .SLAVE_ADDR    (8'h42),
        .ROM_AW        (ROM_AW),
        .POWER_UP_WAIT (PUW),
        .DELAY_CYCLES  (DLY),
        .TIMEOUT       (TMO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .config_start (config_start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sccb         (sccb_if),
        .config_busy  (config_busy),
        .config_done  (config_done),
        .config_error (config_error)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [16];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Controller model: accepts start, stays busy xfer_len+1 cycles, then
    // parks in state 10 for at least `linger` cycles until increment_done.
    bit         model_en = 1'b1;
    int         xfer_len = 5;
    int         linger   = 0;
    int         m_phase  = 0;
    int         m_cnt    = 0;
    int         wr_count = 0;
    logic [7:0] wr_cmd  [64];
    logic [7:0] wr_data [64];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sccb_if.sccb_busy  <= 1'b0;
            sccb_if.sccb_state <= 4'd0;
            m_phase <= 0;
            m_cnt   <= 0;
        end else begin
            case (m_phase)
                0: if (sccb_if.sccb_start && model_en) begin
                    sccb_if.sccb_busy  <= 1'b1;
                    sccb_if.sccb_state <= 4'd1;
                    m_phase <= 1;
                    m_cnt   <= xfer_len;
                    wr_cmd[wr_count[5:0]]  <= sccb_if.sccb_command;
                    wr_data[wr_count[5:0]] <= sccb_if.sccb_data;
                    wr_count <= wr_count + 1;
                    $display("write %0d: addr=%02h cmd=%02h data=%02h", wr_count,
                             sccb_if.sccb_address, sccb_if.sccb_command, sccb_if.sccb_data);
                end
                1: if (m_cnt == 0) begin
                    sccb_if.sccb_busy  <= 1'b0;
                    sccb_if.sccb_state <= 4'd10;
                    m_phase <= 2;
                    m_cnt   <= linger;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (m_cnt == 0 && sccb_if.sccb_increment_done) begin
                    sccb_if.sccb_state <= 4'd0;
                    m_phase <= 0;
                end else if (m_cnt != 0) begin
                    m_cnt <= m_cnt - 1;
                end
            endcase
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sig_sel(input int which);
        case (which)
            0:       return sccb_if.sccb_start;
            1:       return sccb_if.sccb_increment_done;
            2:       return config_done;
            default: return config_error;
        endcase
    endfunction

    // Wait (at negedges) until the selected output reaches `level`; waited is
    // the number of negedges consumed.
    task automatic wait_level(input string tag, input int which, input bit level,
                              input int budget, output int waited);
        waited = 0;
        while (sig_sel(which) != level && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check_eq(tag, 32'(sig_sel(which) == level), 32'd1);
    endtask

    task automatic load_table(input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        config_start = 1'b1;
        @(negedge clk);
        config_start = 1'b0;
    endtask

    int w;
    int base;

    initial begin
        // Reset state and power-up latency
        load_table(16'h1280, 16'h1104, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_eq("rst_start",    32'(sccb_if.sccb_start), 32'd0);
        check_eq("rst_incdone",  32'(sccb_if.sccb_increment_done), 32'd0);
        check_eq("rst_cmd",      32'(sccb_if.sccb_command), 32'h00);
        check_eq("rst_data",     32'(sccb_if.sccb_data), 32'h00);
        check_eq("rst_addr",     32'(rom_addr), 32'd0);
        check_eq("rst_busy",     32'(config_busy), 32'd1);
        check_eq("rst_done",     32'(config_done), 32'd0);
        check_eq("rst_error",    32'(config_error), 32'd0);
        check_eq("slave_addr",   32'(sccb_if.sccb_address), 32'h42);
        reset_n = 1'b1;
        // PWR_WAIT holds PUW+1 cycles, then FETCH and DECODE: start on edge 13.
        wait_level("pwrup_start", 0, 1'b1, 40, w);
        check_eq("pwrup_latency", w, 32'(PUW) + 32'd3);
        check_eq("w0_cmd_out",  32'(sccb_if.sccb_command), 32'h12);
        check_eq("w0_data_out", 32'(sccb_if.sccb_data), 32'h80);
        wait_level("t1_done", 2, 1'b1, 500, w);
        check_eq("t1_busy",   32'(config_busy), 32'd0);
        check_eq("t1_error",  32'(config_error), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("t1_writes", wr_count, 32'd2);
        check_eq("t1_cmd0",   32'(wr_cmd[0]), 32'h12);
        check_eq("t1_data0",  32'(wr_data[0]), 32'h80);
        check_eq("t1_cmd1",   32'(wr_cmd[1]), 32'h11);
        check_eq("t1_data1",  32'(wr_data[1]), 32'h04);
        check_eq("t1_nostart", 32'(sccb_if.sccb_start), 32'd0);
        check_eq("t1_endaddr", 32'(rom_addr), 32'd2);

        // Delay entry between two writes; restart from DONE replays entry 0
        load_table(16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF);
        base = wr_count;
        pulse_start();
        check_eq("t2_restart_addr", 32'(rom_addr), 32'd0);
        check_eq("t2_restart_done", 32'(config_done), 32'd0);
        wait_level("t2_ack_hi", 1, 1'b1, 100, w);
        wait_level("t2_ack_lo", 1, 1'b0, 100, w);
        // FETCH + DECODE + (DLY+1) DELAY + FETCH + DECODE before ISSUE
        wait_level("t2_start2", 0, 1'b1, 200, w);
        check_eq("t2_gap",      w, 32'(DLY) + 32'd5);
        check_eq("t2_nowrite_in_delay", wr_count - base, 32'd1);
        check_eq("t2_cmd",  32'(sccb_if.sccb_command), 32'h11);
        check_eq("t2_data", 32'(sccb_if.sccb_data), 32'h04);
        wait_level("t2_done", 2, 1'b1, 200, w);
        check_eq("t2_writes", wr_count - base, 32'd2);
        check_eq("t2_cmd0", 32'(wr_cmd[base]), 32'h12);

        // Controller lingering in state 10 after busy falls
        linger = 300;
        load_table(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_level("t3_ack_hi", 1, 1'b1, 100, w);
        check_eq("t3_addr_ack", 32'(rom_addr), 32'd0);
        repeat (250) @(negedge clk);
        check_eq("t3_hold",      32'(sccb_if.sccb_increment_done), 32'd1);
        check_eq("t3_addr_hold", 32'(rom_addr), 32'd0);
        wait_level("t3_ack_lo", 1, 1'b0, 200, w);
        check_eq("t3_state_idle", 32'(sccb_if.sccb_state), 32'd0);
        check_eq("t3_addr_inc",   32'(rom_addr), 32'd1);
        wait_level("t3_done", 2, 1'b1, 100, w);
        linger = 0;

        // busy never rises: TIMEOUT+1 ISSUE cycles, then ERROR
        model_en = 1'b0;
        pulse_start();
        wait_level("t4_start", 0, 1'b1, 20, w);
        wait_level("t4_start_drop", 0, 1'b0, 300, w);
        check_eq("t4_issue_cycles", w, 32'(TMO) + 32'd1);
        check_eq("t4_error", 32'(config_error), 32'd1);
        check_eq("t4_done",  32'(config_done), 32'd0);
        check_eq("t4_busy",  32'(config_busy), 32'd0);

        // config_start during ISSUE is ignored
        load_table(16'h1280, 16'h1104, 16'hFFFF, 16'hFFFF);
        base = wr_count;
        pulse_start();
        check_eq("t5_error_clr", 32'(config_error), 32'd0);
        wait_level("t5_start", 0, 1'b1, 20, w);
        pulse_start();
        check_eq("t5_start_kept", 32'(sccb_if.sccb_start), 32'd1);
        check_eq("t5_addr_kept",  32'(rom_addr), 32'd0);
        model_en = 1'b1;
        wait_level("t5_done", 2, 1'b1, 500, w);
        check_eq("t5_writes", wr_count - base, 32'd2);
        check_eq("t5_cmd1",  32'(wr_cmd[base + 1]), 32'h11);
        check_eq("t5_data1", 32'(wr_data[base + 1]), 32'h04);

        // Asynchronous reset during WAIT_XFER of the second write
        xfer_len = 20;
        pulse_start();
        wait_level("t6_ack_hi",  1, 1'b1, 100, w);
        wait_level("t6_ack_lo",  1, 1'b0, 100, w);
        wait_level("t6_start",   0, 1'b1, 20, w);
        wait_level("t6_xfer",    0, 1'b0, 20, w);
        repeat (3) @(negedge clk);
        check_eq("t6_pre_addr", 32'(rom_addr), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_rst_start", 32'(sccb_if.sccb_start), 32'd0);
        check_eq("t6_rst_inc",   32'(sccb_if.sccb_increment_done), 32'd0);
        check_eq("t6_rst_cmd",   32'(sccb_if.sccb_command), 32'h00);
        check_eq("t6_rst_data",  32'(sccb_if.sccb_data), 32'h00);
        check_eq("t6_rst_addr",  32'(rom_addr), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        xfer_len = 5;
        wait_level("t6_restart", 0, 1'b1, 40, w);
        check_eq("t6_restart_lat", w, 32'(PUW) + 32'd3);
        check_eq("t6_first_cmd", 32'(sccb_if.sccb_command), 32'h12);
        wait_level("t6_done", 2, 1'b1, 500, w);

        // Table of only delay entries: incrementing past the last index ends
        for (int i = 0; i < 16; i++) rom[i] = 16'hFFF0;
        base = wr_count;
        pulse_start();
        wait_level("t7_done", 2, 1'b1, 2000, w);
        check_eq("t7_last_addr", 32'(rom_addr), 32'd15);
        check_eq("t7_writes",    wr_count - base, 32'd0);
        check_eq("t7_error",     32'(config_error), 32'd0);
        repeat (10) @(negedge clk);
        check_eq("t7_no_wrap",   32'(rom_addr), 32'd15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
